// File: rtl/datamux_n.sv
// datamux_n: multi-channel byte funnel.
// Each of NCH input channels feeds its own DEPTH-entry FIFO. One byte per
// cycle is drained onto a registered output, arbitrated round-robin
// (MODE=0) or fixed-priority with channel 0 highest (MODE=1).
// Ports:
//   clk     - rising-edge clock
//   resetn  - synchronous active-low reset
//   d       - NCH packed data lanes, channel i in d[i*DW +: DW]
//   dv      - per-channel write strobe
//   obusy   - downstream busy, stalls issue while high
//   clrErr  - clears sticky overflow flags (a same-edge overflow still sets)
//   od      - registered output byte
//   odv     - one-cycle valid pulse per issued byte
//   och     - source channel of od
//   error   - sticky per-channel overflow flags
module datamux_n #(
  parameter int NCH   = 2,
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int MODE  = 0,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NCH*DW-1:0] d,
  input  logic [NCH-1:0]    dv,
  input  logic              obusy,
  input  logic              clrErr,
  output logic [DW-1:0]     od,
  output logic              odv,
  output logic [CW-1:0]     och,
  output logic [NCH-1:0]    error
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0]  mem [NCH][DEPTH];
  logic [AW-1:0]  wp  [NCH];
  logic [AW-1:0]  rp  [NCH];
  logic [AW:0]    cnt [NCH];
  logic [CW-1:0]  last;
  logic [CW-1:0]  gSel;
  logic           grant;
  logic           found;
  int unsigned    idx;
  logic [NCH-1:0] req;
  logic [NCH-1:0] full;
  logic [NCH-1:0] pop;
  logic [NCH-1:0] push;
  logic [NCH-1:0] ovf;

  // Arbitration looks only at registered counts, so a byte written this
  // edge cannot be granted before the next one.
  always_comb begin
    req   = '0;
    full  = '0;
    pop   = '0;
    push  = '0;
    ovf   = '0;
    gSel  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      req[i]  = (cnt[i] != '0);
      full[i] = (cnt[i] == (AW+1)'(DEPTH));
    end
    grant = !obusy && (|req);
    if (MODE == 0) begin
      for (int unsigned k = 1; k <= NCH; k++) begin
        idx = (32'(last) + k) % NCH;
        if (!found && req[idx]) begin
          gSel  = CW'(idx);
          found = 1'b1;
        end
      end
    end else begin
      // Descending scan so the lowest requesting index is the final winner.
      for (int unsigned k = NCH; k > 0; k--) begin
        if (req[k-1]) gSel = CW'(k - 1);
      end
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      pop[i]  = grant && (gSel == CW'(i));
      // A full FIFO still accepts when its head leaves on the same edge.
      push[i] = dv[i] && (!full[i] || pop[i]);
      ovf[i]  = dv[i] && full[i] && !pop[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        wp[i]  <= '0;
        rp[i]  <= '0;
        cnt[i] <= '0;
      end
      od    <= '0;
      och   <= '0;
      odv   <= 1'b0;
      error <= '0;
      last  <= CW'(NCH - 1);
    end else begin
      odv <= grant;
      if (grant) begin
        od  <= mem[gSel][rp[gSel]];
        och <= gSel;
        if (MODE == 0) last <= gSel;
      end
      for (int unsigned i = 0; i < NCH; i++) begin
        if (push[i]) wp[i] <= wp[i] + AW'(1);
        if (pop[i])  rp[i] <= rp[i] + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + (AW+1)'(1);
          2'b01:   cnt[i] <= cnt[i] - (AW+1)'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
      error <= (clrErr ? '0 : error) | ovf;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NCH; i++) begin
      if (resetn && push[i]) mem[i][wp[i]] <= d[i*DW +: DW];
    end
  end

endmodule

// File: tb/tb_datamux_n.sv
module tb_datamux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  // Instance A: NCH=2, MODE=0
  logic [15:0] dA;
  logic [1:0]  dvA;
  logic        obusyA, clrA;
  logic [7:0]  odA;
  logic        odvA;
  logic        ochA;
  logic [1:0]  errA;

  // Instances B (MODE=0) and C (MODE=1): NCH=3, shared inputs
  logic [23:0] d3;
  logic [2:0]  dv3;
  logic        obusy3, clr3;
  logic [7:0]  odB, odC;
  logic        odvB, odvC;
  logic [1:0]  ochB, ochC;
  logic [2:0]  errB, errC;

  datamux_n #(.NCH(2), .DW(8), .DEPTH(4), .MODE(0)) dutA (
    .clk(clk), .resetn(resetn), .d(dA), .dv(dvA), .obusy(obusyA), .clrErr(clrA),
    .od(odA), .odv(odvA), .och(ochA), .error(errA));

  datamux_n #(.NCH(3), .DW(8), .DEPTH(4), .MODE(0)) dutB (
    .clk(clk), .resetn(resetn), .d(d3), .dv(dv3), .obusy(obusy3), .clrErr(clr3),
    .od(odB), .odv(odvB), .och(ochB), .error(errB));

  datamux_n #(.NCH(3), .DW(8), .DEPTH(4), .MODE(1)) dutC (
    .clk(clk), .resetn(resetn), .d(d3), .dv(dv3), .obusy(obusy3), .clrErr(clr3),
    .od(odC), .odv(odvC), .och(ochC), .error(errC));

  typedef struct packed {
    logic [7:0] ch;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [1:0] dv;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       obusy;
    logic       expOdv;
    logic       expOch;
    logic [7:0] expOd;
    logic [1:0] expErr;
  } vec_t;

  exp_t qA[$];
  exp_t qB[$];
  exp_t qC[$];
  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;
  bit   sbEnA = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sbCompare(input string name, inout exp_t q[$], input logic [7:0] ch,
                           input logic [7:0] data);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected output actual=%h/%h required=none", name, ch, data);
    end else begin
      e = q.pop_front();
      if ({ch, data} !== e) begin
        errors++;
        $display("FAIL %s actual ch=%h od=%h required ch=%h od=%h", name, ch, data, e.ch, e.data);
      end
    end
  endtask

  always @(negedge clk) if (sbEnA && odvA) sbCompare("sbA", qA, 8'(ochA), odA);
  always @(negedge clk) if (odvB) sbCompare("sbB", qB, 8'(ochB), odB);
  always @(negedge clk) if (odvC) sbCompare("sbC", qC, 8'(ochC), odC);

  task automatic drainA(input string name, input int budget);
    int n = 0;
    while (qA.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (qA.size() != 0) begin
      errors++;
      $display("FAIL %s drain actual=%0d left required=0", name, qA.size());
      qA.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{2'b01, 8'h41, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00};
    vecs[1]  = '{2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h41, 2'b00};
    vecs[2]  = '{2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h41, 2'b00};
    vecs[3]  = '{2'b11, 8'hA0, 8'hB1, 1'b0, 1'b0, 1'b0, 8'h41, 2'b00};
    vecs[4]  = '{2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'hB1, 2'b00};
    vecs[5]  = '{2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA0, 2'b00};
    vecs[6]  = '{2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA0, 2'b00};
    vecs[7]  = '{2'b10, 8'h00, 8'hC2, 1'b1, 1'b0, 1'b0, 8'hA0, 2'b00};
    vecs[8]  = '{2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA0, 2'b00};
    vecs[9]  = '{2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'hC2, 2'b00};
    vecs[10] = '{2'b01, 8'hD3, 8'hEE, 1'b0, 1'b0, 1'b1, 8'hC2, 2'b00};
    vecs[11] = '{2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'hD3, 2'b00};

    resetn = 1'b0;
    dA = '0; dvA = '0; obusyA = 1'b0; clrA = 1'b0;
    d3 = '0; dv3 = '0; obusy3 = 1'b0; clr3 = 1'b0;
    tick();
    tick();
    chk("resetA", {odvA, ochA, odA, errA}, 32'h0);
    chk("resetB", {odvB, ochB, odB, errB}, 32'h0);
    resetn = 1'b1;

    // Table-driven cycles on A: latency, round-robin, busy stall, ignored lanes
    for (int i = 0; i < 12; i++) begin
      dvA    = vecs[i].dv;
      dA     = {vecs[i].d1, vecs[i].d0};
      obusyA = vecs[i].obusy;
      tick();
      chk($sformatf("vec%0d", i), {odvA, ochA, odA, errA},
          {vecs[i].expOdv, vecs[i].expOch, vecs[i].expOd, vecs[i].expErr});
    end
    dvA = '0;
    tick();
    sbEnA = 1'b1;

    // B/C: two bytes per channel preloaded while busy, then released
    obusy3 = 1'b1;
    for (int j = 0; j < 2; j++) begin
      dv3 = 3'b111;
      d3  = {8'(8'h20 + j), 8'(8'h10 + j), 8'(8'h00 + j)};
      tick();
    end
    dv3 = '0;
    qB.push_back('{8'd0, 8'h00}); qB.push_back('{8'd1, 8'h10}); qB.push_back('{8'd2, 8'h20});
    qB.push_back('{8'd0, 8'h01}); qB.push_back('{8'd1, 8'h11}); qB.push_back('{8'd2, 8'h21});
    qC.push_back('{8'd0, 8'h00}); qC.push_back('{8'd0, 8'h01}); qC.push_back('{8'd1, 8'h10});
    qC.push_back('{8'd1, 8'h11}); qC.push_back('{8'd2, 8'h20}); qC.push_back('{8'd2, 8'h21});
    obusy3 = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    #1;
    chk("rrSixCycles", qB.size(), 0);
    chk("prioSixCycles", qC.size(), 0);
    tick();
    chk("rrIdle", odvB, 1'b0);
    qB.delete();
    qC.delete();

    // A: overflow on a full FIFO, sticky flag, clear
    obusyA = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dvA = 2'b10;
      dA  = {8'(8'h10 + i), 8'h00};
      tick();
    end
    dvA = '0;
    chk("ovfSet", errA, 2'b10);
    for (int i = 0; i < 4; i++) qA.push_back('{8'd1, 8'(8'h10 + i)});
    obusyA = 1'b0;
    drainA("ovfDrain", 12);
    tick();
    tick();
    chk("ovfSticky", errA, 2'b10);
    clrA = 1'b1;
    tick();
    clrA = 1'b0;
    chk("ovfClear", errA, 2'b00);

    // A: write into a full FIFO on the same edge as its pop
    obusyA = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dvA = 2'b01;
      dA  = {8'h00, 8'(8'h20 + i)};
      tick();
    end
    qA.push_back('{8'd0, 8'h20});
    obusyA = 1'b0;
    dvA = 2'b01;
    dA  = {8'h00, 8'h24};
    tick();
    chk("fullPopPush", {odvA, odA, errA}, {1'b1, 8'h20, 2'b00});
    obusyA = 1'b1;
    dA  = {8'h00, 8'h25};
    tick();
    chk("fullStill", errA, 2'b01);
    dvA = '0;
    clrA = 1'b1;
    tick();
    clrA = 1'b0;
    chk("fullClear", errA, 2'b00);
    for (int i = 1; i < 5; i++) qA.push_back('{8'd0, 8'(8'h20 + i)});
    obusyA = 1'b0;
    drainA("fullDrain", 12);
    tick();

    // A: reset mid-stream with queued bytes and a set error flag
    obusyA = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dvA = {1'b1, (i < 3) ? 1'b1 : 1'b0};
      dA  = {8'(8'h60 + i), 8'(8'h30 + i)};
      tick();
    end
    chk("preResetErr", errA, 2'b10);
    resetn = 1'b0;
    obusyA = 1'b0;
    dvA = 2'b01;
    dA  = {8'h00, 8'h99};
    clrA = 1'b0;
    tick();
    chk("midReset", {odvA, ochA, odA, errA}, 32'h0);
    resetn = 1'b1;
    dvA = '0;
    tick();
    chk("relEdge1", odvA, 1'b0);
    tick();
    chk("relEdge2", odvA, 1'b0);
    tick();
    chk("relEdge3", {odvA, errA}, 3'b000);
    qA.push_back('{8'd0, 8'h55});
    dvA = 2'b01;
    dA  = {8'h00, 8'h55};
    tick();
    dvA = '0;
    chk("lat1", odvA, 1'b0);
    tick();
    chk("lat2", {odvA, ochA, odA}, {1'b1, 1'b0, 8'h55});
    tick();
    chk("latDone", odvA, 1'b0);
    drainA("latDrain", 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datamux_n.md
DATAMUX_N -- requirements
Module: datamux_n

Interface
REQ-001 SHALL have parameter NCH, default 2: number of input byte channels, legal range 2..8.
REQ-002 SHALL have parameter DW, default 8: data width per channel.
REQ-003 SHALL have parameter DEPTH, default 4: per-channel FIFO depth, power of 2, legal range 2..16.
REQ-004 SHALL have parameter MODE, default 0: 0 selects round-robin arbitration, 1 selects fixed priority with channel 0 highest.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port resetn, input, 1: synchronous active-low reset.
REQ-007 SHALL have port d, input, NCH*DW: channel i data in bits [i*DW +: DW].
REQ-008 SHALL have port dv, input, NCH: channel i write strobe, one byte per high cycle.
REQ-009 SHALL have port obusy, input, 1: downstream busy; no byte issued while high.
REQ-010 SHALL have port clrErr, input, 1: clears all error bits.
REQ-011 SHALL have port od, output, DW: registered output byte.
REQ-012 SHALL have port odv, output, NCH-independent 1: one-cycle valid pulse per issued byte.
REQ-013 SHALL have port och, output, CW=max(1,clog2(NCH)): source channel of od.
REQ-014 SHALL have port error, output, NCH: sticky per-channel overflow flags.

Function
REQ-015 SHALL give each channel an independent DEPTH-entry FIFO with a write pointer, a read pointer and a count of clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
REQ-016 SHALL push d[i] at an edge where dv[i]=1 and the FIFO is not full, or is full and popped at the same edge.
REQ-017 SHALL drop the byte when dv[i]=1 and the FIFO is full with no pop that edge, set error[i], and leave FIFO contents unchanged.
REQ-018 SHALL form candidate set R = {i : count[i] != 0}, using counts registered before the edge; a byte pushed at edge k is never eligible before edge k+1.
REQ-019 SHALL grant exactly one channel g at an edge where obusy=0 and R is non-empty: pop FIFO g, load od with its head byte, load och with g, and drive odv=1 for the following cycle.
REQ-020 SHALL drive odv=0 after any edge with obusy=1 or R empty; od and och then hold their last values.
REQ-021 SHALL have a minimum latency of 2 edges from a dv[i] sample to odv=1 on an idle block: push at edge k, grant at edge k+1.
REQ-022 SHALL sustain one byte per cycle while obusy=0 and R is non-empty.
REQ-023 SHALL, in MODE=0, choose g as the first member of R searching upward from last+1 modulo NCH, then set last=g; last is unchanged when no grant occurs.
REQ-024 SHALL, in MODE=1, choose g as the lowest index in R; last is unused.
REQ-025 SHALL preserve per-channel byte order; no byte is duplicated or lost except per REQ-017.
REQ-026 SHALL clear all error bits at an edge where clrErr=1, except that an overflow at that same edge sets its bit (set wins).
REQ-027 SHALL ignore the value of d[i] in cycles with dv[i]=0.

Reset
REQ-028 SHALL, at an edge with resetn=0: empty all FIFOs (pointers and counts 0), set od=0, och=0, odv=0, error=0, and last=NCH-1 so channel 0 wins first in MODE=0; it ignores dv and clrErr at that edge.
REQ-029 SHALL abandon any pending data when reset is asserted mid-stream, with no output on the first edge after release; FIFO RAM contents need no reset.

Verification
REQ-030 SHALL be verified with NCH=2, MODE=0: dv0 with 0x41 at edge 1 -> odv=1, od=0x41, och=0 after edge 2, then odv=0.
REQ-031 SHALL be verified with NCH=3, MODE=0: each channel preloaded with 2 bytes under obusy=1, then obusy=0 -> och sequence 0,1,2,0,1,2 on 6 consecutive odv cycles.
REQ-032 SHALL be verified with NCH=3, MODE=1, same preload -> och sequence 0,0,1,1,2,2.
REQ-033 SHALL be verified with DEPTH=4, obusy=1: 5 writes 0x10..0x14 on channel 1 -> error[1]=1; after obusy=0, output is 0x10..0x13 only; a clrErr pulse -> error=0.
REQ-034 SHALL be verified with a full FIFO, obusy=0 and dv=1 at the same edge -> the byte is accepted, the count stays at 4 and error stays 0.
REQ-035 SHALL be verified with resetn=0 for one edge while 3 bytes are queued -> odv=0, error=0, and no stale byte appears afterwards; the next write reappears with latency 2.
